e203_ifu_dynbpu: RTL and testbench

Parametrised next-generation IFU branch predictor. Replaces static backward-taken prediction for Bxx with a BHT of 2-bit saturating counters, updated by EXU resolution. Adds a return-address stack (RAS) that predicts JALR-x1 returns without waiting on x1 dependencies. Keeps the existing JALR rs1 dependency/regfile-read handshake. Sits between the IFU mini-decoder and the next-PC adder.

---
 rtl/e203_ifu_dynbpu_pkg.sv | 16 +
 rtl/e203_ifu_ras.sv | 67 ++++++
 rtl/e203_ifu_dynbpu.sv | 137 +++++++++++++
 tb/tb_e203_ifu_dynbpu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/e203_ifu_dynbpu_pkg.sv
// Shared constants and helpers for the dynamic IFU branch predictor.
// Holds the BHT counter reset value and the saturating update rule.
package e203_ifu_dynbpu_pkg;

  // Weakly not-taken
  localparam logic [1:0] BHT_RST = 2'b01;

  function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
    if (taken) begin
      return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end else begin
      return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
  endfunction

endpackage

// File: rtl/e203_ifu_ras.sv
// Return-address stack: circular top pointer, occupancy count and storage.
// A full stack overwrites its oldest entry; a simultaneous push/pop replaces the top.
module e203_ifu_ras #(
  parameter int unsigned PC_SIZE   = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [PC_SIZE-1:0] push_addr,
  output logic [PC_SIZE-1:0] top,
  output logic               nonempty
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PC_SIZE-1:0] stack_q [RAS_DEPTH];
  logic               wr_en;
  logic [PW-1:0]      wr_ptr;

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (flush) begin
      cnt_d = '0;
    end else if (push && pop) begin
      wr_en = 1'b1;
      // Pop-then-push on an empty stack degenerates to a plain push
      if (cnt_q == '0) begin
        wr_ptr = ptr_q + 1'b1;
        ptr_d  = ptr_q + 1'b1;
        cnt_d  = CW'(1);
      end
    end else if (push) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_q + 1'b1;
      ptr_d  = ptr_q + 1'b1;
      if (cnt_q != CW'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) stack_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (wr_en) stack_q[wr_ptr] <= push_addr;
    end
  end

  assign top      = stack_q[ptr_q];
  assign nonempty = (cnt_q != '0);

endmodule

// File: rtl/e203_ifu_dynbpu.sv
// IFU branch predictor: 2-bit BHT for Bxx, RAS for returns, and the JALR rs1
// dependency / regfile-read handshake feeding the next-PC adder.
module e203_ifu_dynbpu
  import e203_ifu_dynbpu_pkg::*;
#(
  parameter int unsigned PC_SIZE     = 32,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned RFIDX_WIDTH = 5,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned RAS_DEPTH   = 4,
  parameter int unsigned RAS_EN      = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_SIZE-1:0]     pc,
  input  logic                   dec_i_valid,
  input  logic                   dec_i_fire,
  input  logic                   dec_jal,
  input  logic                   dec_jalr,
  input  logic                   dec_bxx,
  input  logic                   dec_rv32,
  input  logic [XLEN-1:0]        dec_bjp_imm,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] dec_rdidx,
  input  logic                   oitf_empty,
  input  logic                   ir_empty,
  input  logic                   ir_rs1en,
  input  logic                   ir_valid_clr,
  input  logic                   jalr_rs1idx_cam_irrdidx,
  input  logic [XLEN-1:0]        rf2bpu_x1,
  input  logic [XLEN-1:0]        rf2bpu_rs1,
  input  logic                   upd_valid,
  input  logic [PC_SIZE-1:0]     upd_pc,
  input  logic                   upd_taken,
  input  logic                   ras_flush,
  output logic                   bpu_wait,
  output logic                   prdt_taken,
  output logic [PC_SIZE-1:0]     prdt_pc_add_op1,
  output logic [PC_SIZE-1:0]     prdt_pc_add_op2,
  output logic                   bpu2rf_rs1_ena
);

  localparam int unsigned BHT_IW = $clog2(BHT_ENTRIES);

  // BHT
  logic [1:0]        bht_q [BHT_ENTRIES];
  logic [BHT_IW-1:0] rd_idx, upd_idx;

  assign rd_idx  = pc[BHT_IW:1];
  assign upd_idx = upd_pc[BHT_IW:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= BHT_RST;
    end else if (upd_valid) begin
      bht_q[upd_idx] <= bht_next(bht_q[upd_idx], upd_taken);
    end
  end

  logic unused_upd_pc;
  assign unused_upd_pc = ^{upd_pc[0], upd_pc[PC_SIZE-1:BHT_IW+1]};

  // Decode classification
  logic rs1_x0, rs1_x1, rd_x1, is_call, is_ret;

  assign rs1_x0  = (dec_jalr_rs1idx == RFIDX_WIDTH'(0));
  assign rs1_x1  = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
  assign rd_x1   = (dec_rdidx == RFIDX_WIDTH'(1));
  assign is_call = (dec_jal | dec_jalr) & rd_x1;
  assign is_ret  = dec_jalr & rs1_x1 & ~rd_x1;

  // RAS
  logic               ras_push, ras_pop, ras_nonempty, ras_hit;
  logic [PC_SIZE-1:0] ras_push_addr, ras_top;

  assign ras_push      = dec_i_fire & is_call;
  // Both plain returns and rs1=x1/rd=x1 pop-then-push pop the stack
  assign ras_pop       = dec_i_fire & dec_jalr & rs1_x1;
  assign ras_push_addr = pc + (dec_rv32 ? PC_SIZE'(4) : PC_SIZE'(2));

  if (RAS_EN != 0) begin : g_ras
    e203_ifu_ras #(
      .PC_SIZE   (PC_SIZE),
      .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ras_pop),
      .flush     (ras_flush),
      .push_addr (ras_push_addr),
      .top       (ras_top),
      .nonempty  (ras_nonempty)
    );
  end else begin : g_no_ras
    assign ras_top      = '0;
    assign ras_nonempty = 1'b0;
    logic unused_ras;
    assign unused_ras = ^{ras_push, ras_pop, ras_flush, ras_push_addr};
  end

  assign ras_hit = is_ret & ras_nonempty;

  // JALR dependency and regfile-read handshake
  logic dep_x1, dep_xn, ir_clr, rdrf_q, rdrf_set;

  assign dep_x1   = dec_i_valid & dec_jalr & rs1_x1 & ~ras_hit
                  & (~oitf_empty | jalr_rs1idx_cam_irrdidx);
  assign dep_xn   = dec_i_valid & dec_jalr & ~rs1_x0 & ~rs1_x1 & (~oitf_empty | ~ir_empty);
  assign ir_clr   = dep_xn & oitf_empty & ~ir_empty & (ir_valid_clr | ~ir_rs1en);
  assign rdrf_set = ~rdrf_q & dec_i_valid & dec_jalr & ~rs1_x0 & ~rs1_x1 & (~dep_xn | ir_clr);

  // One-shot: a set cycle is always followed by a clear cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdrf_q <= 1'b0;
    else        rdrf_q <= rdrf_set;
  end

  assign bpu2rf_rs1_ena = rdrf_set;
  assign bpu_wait       = dep_x1 | dep_xn | rdrf_set;
  assign prdt_taken     = dec_jal | dec_jalr | (dec_bxx & bht_q[rd_idx][1]);

  always_comb begin
    prdt_pc_add_op1 = rf2bpu_rs1[PC_SIZE-1:0];
    prdt_pc_add_op2 = dec_bjp_imm[PC_SIZE-1:0];
    if (ras_hit) begin
      prdt_pc_add_op1 = ras_top;
    end else if (dec_bxx | dec_jal) begin
      prdt_pc_add_op1 = pc;
    end else if (dec_jalr & rs1_x0) begin
      prdt_pc_add_op1 = '0;
    end else if (dec_jalr & rs1_x1) begin
      prdt_pc_add_op1 = rf2bpu_x1[PC_SIZE-1:0];
    end
  end

endmodule

// File: tb/tb_e203_ifu_dynbpu.sv
// Directed scoreboard bench for e203_ifu_dynbpu: expectations are queued when a
// step is driven and popped/compared at the following falling edge.
module tb_e203_ifu_dynbpu;

  localparam logic [31:0] X1V = 32'hAAAA_0000;
  localparam logic [31:0] RSV = 32'h5555_0000;
  localparam logic [31:0] BX  = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc;
  logic        dec_i_valid, dec_i_fire, dec_jal, dec_jalr, dec_bxx, dec_rv32;
  logic [31:0] dec_bjp_imm;
  logic [4:0]  dec_jalr_rs1idx, dec_rdidx;
  logic        oitf_empty, ir_empty, ir_rs1en, ir_valid_clr, jalr_rs1idx_cam_irrdidx;
  logic [31:0] rf2bpu_x1, rf2bpu_rs1;
  logic        upd_valid, upd_taken, ras_flush;
  logic [31:0] upd_pc;
  logic        bpu_wait, prdt_taken, bpu2rf_rs1_ena;
  logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

  e203_ifu_dynbpu #(
    .PC_SIZE     (32),
    .XLEN        (32),
    .RFIDX_WIDTH (5),
    .BHT_ENTRIES (64),
    .RAS_DEPTH   (4),
    .RAS_EN      (1)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .pc                      (pc),
    .dec_i_valid             (dec_i_valid),
    .dec_i_fire              (dec_i_fire),
    .dec_jal                 (dec_jal),
    .dec_jalr                (dec_jalr),
    .dec_bxx                 (dec_bxx),
    .dec_rv32                (dec_rv32),
    .dec_bjp_imm             (dec_bjp_imm),
    .dec_jalr_rs1idx         (dec_jalr_rs1idx),
    .dec_rdidx               (dec_rdidx),
    .oitf_empty              (oitf_empty),
    .ir_empty                (ir_empty),
    .ir_rs1en                (ir_rs1en),
    .ir_valid_clr            (ir_valid_clr),
    .jalr_rs1idx_cam_irrdidx (jalr_rs1idx_cam_irrdidx),
    .rf2bpu_x1               (rf2bpu_x1),
    .rf2bpu_rs1              (rf2bpu_rs1),
    .upd_valid               (upd_valid),
    .upd_pc                  (upd_pc),
    .upd_taken               (upd_taken),
    .ras_flush               (ras_flush),
    .bpu_wait                (bpu_wait),
    .prdt_taken              (prdt_taken),
    .prdt_pc_add_op1         (prdt_pc_add_op1),
    .prdt_pc_add_op2         (prdt_pc_add_op2),
    .bpu2rf_rs1_ena          (bpu2rf_rs1_ena)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        taken;
    logic        bwait;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        ena;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic expect_out(input string tag, input logic t, input logic w,
                            input logic [31:0] o1, input logic [31:0] o2, input logic e);
    exp_t x;
    x.tag = tag; x.taken = t; x.bwait = w; x.op1 = o1; x.op2 = o2; x.ena = e;
    sb.push_back(x);
  endtask

  task automatic check_one(input string tag, input string fld,
                           input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, expv);
  endtask

  // Compare at the falling edge, then return just after the next rising edge
  task automatic cyc();
    exp_t x;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_total++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      x = sb.pop_front();
      check_one(x.tag, "taken", {31'b0, prdt_taken}, {31'b0, x.taken});
      check_one(x.tag, "wait", {31'b0, bpu_wait}, {31'b0, x.bwait});
      check_one(x.tag, "op1", prdt_pc_add_op1, x.op1);
      check_one(x.tag, "op2", prdt_pc_add_op2, x.op2);
      check_one(x.tag, "ena", {31'b0, bpu2rf_rs1_ena}, {31'b0, x.ena});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc = '0; dec_i_valid = 0; dec_i_fire = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
    dec_rv32 = 1; dec_bjp_imm = '0; dec_jalr_rs1idx = '0; dec_rdidx = '0;
    oitf_empty = 1; ir_empty = 1; ir_rs1en = 0; ir_valid_clr = 0;
    jalr_rs1idx_cam_irrdidx = 0; upd_valid = 0; upd_pc = '0; upd_taken = 0; ras_flush = 0;
  endtask

  task automatic do_bxx(input logic [31:0] p, input logic uv, input logic ut);
    idle();
    pc = p; dec_i_valid = 1; dec_i_fire = 1; dec_bxx = 1; dec_bjp_imm = BX;
    upd_valid = uv; upd_pc = 32'h100; upd_taken = ut;
  endtask

  task automatic do_jal(input logic [31:0] p, input logic rv32);
    idle();
    pc = p; dec_i_valid = 1; dec_i_fire = 1; dec_jal = 1; dec_rv32 = rv32;
    dec_rdidx = 5'd1; dec_bjp_imm = 32'h40;
  endtask

  task automatic do_jalr(input logic [31:0] p, input logic [4:0] rs1, input logic [4:0] rd,
                         input logic [31:0] imm, input logic fire);
    idle();
    pc = p; dec_i_valid = 1; dec_i_fire = fire; dec_jalr = 1;
    dec_jalr_rs1idx = rs1; dec_rdidx = rd; dec_bjp_imm = imm;
  endtask

  logic [31:0] call_pc [5];
  logic [31:0] ret_addr [4];

  initial begin
    rf2bpu_x1  = X1V;
    rf2bpu_rs1 = RSV;
    rst_n = 1'b0;
    idle();
    expect_out("reset", 0, 0, RSV, 0, 0); cyc();
    rst_n = 1'b1;
    expect_out("idle", 0, 0, RSV, 0, 0); cyc();

    // BHT: counter 01 -> same-cycle read sees pre-update value, then saturates both ways
    do_bxx(32'h100, 0, 0); expect_out("bxx_init",  0, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h100, 1, 1); expect_out("bxx_same",  0, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h104, 0, 0); expect_out("bxx_other", 0, 0, 32'h104, BX, 0); cyc();
    do_bxx(32'h100, 1, 1); expect_out("bxx_10",    1, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h100, 1, 1); expect_out("bxx_11",    1, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h100, 1, 0); expect_out("bxx_sat11", 1, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h100, 1, 0); expect_out("bxx_dn10",  1, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h100, 1, 0); expect_out("bxx_dn01",  0, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h100, 1, 0); expect_out("bxx_dn00",  0, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h100, 1, 1); expect_out("bxx_sat00", 0, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h100, 0, 0); expect_out("bxx_up01",  0, 0, 32'h100, BX, 0); cyc();

    // Call then return: RAS supplies op1 and suppresses the x1 wait
    do_jal(32'h200, 1); expect_out("call_200", 1, 0, 32'h200, 32'h40, 0); cyc();
    do_jalr(32'h300, 5'd1, 5'd0, 0, 1); oitf_empty = 0;
    expect_out("ret_200", 1, 0, 32'h204, 0, 0); cyc();

    // Five calls into a 4-deep RAS, then five returns
    call_pc = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
    ret_addr = '{32'h5002, 32'h4004, 32'h3004, 32'h2004};
    for (int i = 0; i < 5; i++) begin
      do_jal(call_pc[i], (i != 4));
      expect_out($sformatf("call%0d", i + 1), 1, 0, call_pc[i], 32'h40, 0); cyc();
    end
    for (int i = 0; i < 4; i++) begin
      do_jalr(32'h6000, 5'd1, 5'd0, 0, 1); oitf_empty = 0;
      expect_out($sformatf("ret%0d", i + 1), 1, 0, ret_addr[i], 0, 0); cyc();
    end
    do_jalr(32'h6000, 5'd1, 5'd0, 0, 0); oitf_empty = 0;
    expect_out("ret_empty", 1, 1, X1V, 0, 0); cyc();

    // rs1=x1, rd=x1 replaces the top entry
    do_jal(32'h600, 1); expect_out("call_600", 1, 0, 32'h600, 32'h40, 0); cyc();
    do_jalr(32'h700, 5'd1, 5'd1, 32'h10, 1);
    expect_out("poppush", 1, 0, X1V, 32'h10, 0); cyc();
    do_jalr(32'h710, 5'd1, 5'd0, 0, 1); expect_out("ret_704", 1, 0, 32'h704, 0, 0); cyc();
    do_jalr(32'h720, 5'd1, 5'd0, 0, 1); expect_out("ret_pp_empty", 1, 0, X1V, 0, 0); cyc();

    // Flush wins over a same-cycle push
    do_jal(32'h900, 1); expect_out("call_900", 1, 0, 32'h900, 32'h40, 0); cyc();
    do_jal(32'h800, 1); ras_flush = 1;
    expect_out("call_flush", 1, 0, 32'h800, 32'h40, 0); cyc();
    do_jalr(32'h810, 5'd1, 5'd0, 0, 1); expect_out("ret_flushed", 1, 0, X1V, 0, 0); cyc();

    do_jalr(32'h820, 5'd1, 5'd0, 0, 0); jalr_rs1idx_cam_irrdidx = 1;
    expect_out("x1_cam", 1, 1, X1V, 0, 0); cyc();

    // JALR rs1=x5: one-shot regfile read
    do_jalr(32'hA00, 5'd5, 5'd0, 32'h8, 0); expect_out("rdrf_set", 1, 1, RSV, 8, 1); cyc();
    dec_i_fire = 1; expect_out("rdrf_clr", 1, 0, RSV, 8, 0); cyc();
    idle(); expect_out("idle2", 0, 0, RSV, 0, 0); cyc();

    do_jalr(32'hA00, 5'd5, 5'd0, 32'h8, 0); oitf_empty = 0;
    expect_out("xn_oitf", 1, 1, RSV, 8, 0); cyc();
    do_jalr(32'hA00, 5'd5, 5'd0, 32'h8, 0); ir_empty = 0; ir_rs1en = 1;
    expect_out("xn_ir", 1, 1, RSV, 8, 0); cyc();
    ir_valid_clr = 1; expect_out("xn_irclr", 1, 1, RSV, 8, 1); cyc();
    idle(); expect_out("idle3", 0, 0, RSV, 0, 0); cyc();
    idle(); expect_out("idle4", 0, 0, RSV, 0, 0); cyc();

    // Reset while the one-shot is high
    do_bxx(32'h100, 1, 1); expect_out("bht_pre", 0, 0, 32'h100, BX, 0); cyc();
    do_bxx(32'h100, 0, 0); expect_out("bht_pre2", 1, 0, 32'h100, BX, 0); cyc();
    do_jalr(32'hB00, 5'd5, 5'd0, 32'h8, 0); expect_out("rst_set", 1, 1, RSV, 8, 1); cyc();
    rst_n = 1'b0;
    expect_out("rst_mid", 1, 1, RSV, 8, 1); cyc();
    rst_n = 1'b1;
    do_bxx(32'h100, 0, 0); expect_out("bht_post_rst", 0, 0, 32'h100, BX, 0); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
